// File: rtl/wavelet_bank_sequencer.sv
// Wavelet FIR bank sequencer: builds the shared tap window from a serial
// sample stream, strobes the filter bank once per new sample after warm-up,
// then scales, saturates and serialises every filter's sum.
module wavelet_bank_sequencer #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_ELEM      = 7,
  parameter int NUM_FILTERS   = 4,
  parameter int OUT_BITS      = 8,
  parameter int SUM_SHIFT     = 7,
  localparam int IDX_W        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_sample_valid,
  input  logic [BITS_PER_ELEM-1:0]          i_sample,
  output logic                              o_sample_ready,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
  output logic                              o_start_calc,
  input  logic [NUM_FILTERS*32-1:0]         i_sums,
  output logic [OUT_BITS-1:0]               o_data,
  output logic [IDX_W-1:0]                  o_filter_idx,
  output logic                              o_data_valid,
  input  logic                              i_data_ready,
  output logic                              o_window_full
);

  localparam int TAP_W = NUM_ELEM * BITS_PER_ELEM;
  localparam int CNT_W = $clog2(NUM_ELEM + 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NUM_ELEM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FILTERS - 1);
  localparam logic signed [31:0] SAT_MAX = 32'((2 ** (OUT_BITS - 1)) - 1);
  localparam logic signed [31:0] SAT_MIN = 32'(-(2 ** (OUT_BITS - 1)));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CAPTURE,
    ST_OUT
  } state_t;

  state_t              state_q;
  logic [TAP_W-1:0]    taps_q;
  logic [CNT_W-1:0]    fill_q;
  logic                start_calc_q;
  logic [OUT_BITS-1:0] data_q;
  logic [IDX_W-1:0]    idx_q;
  logic                valid_q;
  logic                full_q;
  logic [OUT_BITS-1:0] buf_q [NUM_FILTERS];

  logic                accept;
  logic [TAP_W-1:0]    taps_d;
  logic [CNT_W-1:0]    fill_d;
  logic [IDX_W-1:0]    idx_d;
  logic [OUT_BITS-1:0] sat_vals [NUM_FILTERS];

  // Per-filter scaling: arithmetic shift, then clamp to the signed output range
  for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_sat
    logic signed [31:0] shifted;
    assign shifted = $signed(i_sums[32*gi +: 32]) >>> SUM_SHIFT;
    assign sat_vals[gi] = (shifted > SAT_MAX) ? SAT_MAX[OUT_BITS-1:0] :
                          (shifted < SAT_MIN) ? SAT_MIN[OUT_BITS-1:0] :
                                                shifted[OUT_BITS-1:0];
  end

  // Next-state helpers: window shift (newest sample into element 0),
  // saturating fill count and the next output index
  always_comb begin
    accept = i_sample_valid && (state_q == ST_IDLE);
    taps_d = {taps_q[TAP_W-BITS_PER_ELEM-1:0], i_sample};
    fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    idx_d  = idx_q + 1'b1;
  end

  // Sequencer FSM with registered outputs; result buffer filled in CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      taps_q       <= '0;
      fill_q       <= '0;
      start_calc_q <= 1'b0;
      data_q       <= '0;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      full_q       <= 1'b0;
      for (int f = 0; f < NUM_FILTERS; f++) begin
        buf_q[f] <= '0;
      end
    end else begin
      start_calc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            taps_q <= taps_d;
            fill_q <= fill_d;
            // Calc only once the window holds NUM_ELEM real samples
            if (fill_d == FILL_MAX) begin
              full_q       <= 1'b1;
              start_calc_q <= 1'b1;
              state_q      <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          for (int f = 0; f < NUM_FILTERS; f++) begin
            buf_q[f] <= sat_vals[f];
          end
          idx_q   <= '0;
          data_q  <= sat_vals[0];
          valid_q <= 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          // Hold data/index stable until the consumer takes them
          if (i_data_ready) begin
            if (idx_q == IDX_LAST) begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q  <= idx_d;
              data_q <= buf_q[idx_d];
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sample_ready = (state_q == ST_IDLE);
  assign o_taps         = taps_q;
  assign o_start_calc   = start_calc_q;
  assign o_data         = data_q;
  assign o_filter_idx   = idx_q;
  assign o_data_valid   = valid_q;
  assign o_window_full  = full_q;

endmodule

// File: tb/tb_wavelet_bank_sequencer.sv
// Self-checking bench for wavelet_bank_sequencer: a table of stubbed filter
// sums with hand-computed results, directed corner sequences, and a random
// phase checked against a transaction-level reference model.
module tb_wavelet_bank_sequencer;

  localparam int B  = 8;
  localparam int NE = 7;
  localparam int NF = 4;
  localparam int SH = 7;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_sample_valid;
  logic [B-1:0]    i_sample;
  logic            o_sample_ready;
  logic [NE*B-1:0] o_taps;
  logic            o_start_calc;
  logic [NF*32-1:0] i_sums;
  logic [7:0]      o_data;
  logic [IW-1:0]   o_filter_idx;
  logic            o_data_valid;
  logic            i_data_ready;
  logic            o_window_full;

  int errors = 0;
  int checks = 0;

  wavelet_bank_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sample_valid(i_sample_valid),
    .i_sample      (i_sample),
    .o_sample_ready(o_sample_ready),
    .o_taps        (o_taps),
    .o_start_calc  (o_start_calc),
    .i_sums        (i_sums),
    .o_data        (o_data),
    .o_filter_idx  (o_filter_idx),
    .o_data_valid  (o_data_valid),
    .i_data_ready  (i_data_ready),
    .o_window_full (o_window_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sums [NF];
    int exp  [NF];
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference scaling: floor division by 2^SH, clamped to signed 8 bits
  function automatic int sat_ref(input int s);
    real r;
    r = $floor(real'(s) / real'(1 << SH));
    if (r > 127.0) return 127;
    if (r < -128.0) return -128;
    return int'(r);
  endfunction

  function automatic longint data_s();
    return longint'($signed(o_data));
  endfunction

  task automatic set_sums(input int row);
    for (int f = 0; f < NF; f++) i_sums[32*f +: 32] = vecs[row].sums[f];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_sample_ready, 1);
    check({tag, "_taps"}, longint'(o_taps), 0);
    check({tag, "_calc"}, o_start_calc, 0);
    check({tag, "_data"}, longint'(o_data), 0);
    check({tag, "_idx"}, longint'(o_filter_idx), 0);
    check({tag, "_valid"}, o_data_valid, 0);
    check({tag, "_full"}, o_window_full, 0);
  endtask

  // One full transaction with ready held high, checked against a table row
  task automatic run_tx(input int s, input int row);
    int n;
    set_sums(row);
    i_sample       = B'(s);
    i_sample_valid = 1'b1;
    i_data_ready   = 1'b1;
    n = 0;
    while (!o_sample_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_wait", o_sample_ready, 1);
    tick();
    i_sample_valid = 1'b0;
    check("calc_strobe", o_start_calc, 1);
    check("calc_full", o_window_full, 1);
    check("calc_taps_el0", longint'(o_taps[7:0]), s & 255);
    tick();
    check("calc_single", o_start_calc, 0);
    check("capture_novalid", o_data_valid, 0);
    tick();
    for (int f = 0; f < NF; f++) begin
      check("out_valid", o_data_valid, 1);
      check("out_data", data_s(), vecs[row].exp[f]);
      check("out_idx", longint'(o_filter_idx), f);
      tick();
    end
    check("out_done", o_data_valid, 0);
    check("ready_back", o_sample_ready, 1);
    $display("tx sample=%0d row=%0d complete", s, row);
  endtask

  initial begin
    logic [NE*B-1:0] exp_taps;
    int win [NE];
    int accepted;
    bit busy, cur_busy, exp_calc, exp_valid, vld, rdy;
    int valid_from, smp, txn;
    int q_data [$];
    int q_idx  [$];

    vecs[0].sums = '{1000, -1000, 40000, -40000};
    vecs[0].exp  = '{7, -8, 127, -128};
    vecs[1].sums = '{0, 127, 128, -1};
    vecs[1].exp  = '{0, 0, 1, -1};
    vecs[2].sums = '{16383, 16384, -16384, -16385};
    vecs[2].exp  = '{127, 127, -128, -128};
    vecs[3].sums = '{-128, -129, 255, 2147483647};
    vecs[3].exp  = '{-1, -2, 1, 127};

    // Async reset: outputs must clear before any clock edge
    rst_n = 1'b1;
    i_sample_valid = 1'b0;
    i_sample = '0;
    i_sums = '0;
    i_data_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst0");
    tick();
    rst_n = 1'b1;
    #1;

    // Warm-up: six samples never trigger a calc
    for (int k = 1; k <= 6; k++) begin
      i_sample = B'(k);
      i_sample_valid = 1'b1;
      check("warm_ready", o_sample_ready, 1);
      tick();
      check("warm_calc", o_start_calc, 0);
      check("warm_full", o_window_full, 0);
    end
    run_tx(7, 0);
    for (int k = 0; k < NE; k++) exp_taps[B*k +: B] = B'(7 - k);
    check("warm_taps", longint'(o_taps), longint'(exp_taps));

    // Table of scaling / saturation cases
    for (int r = 1; r < 4; r++) run_tx(20 + r, r);

    // Backpressure plus busy input held during CALC/CAPTURE/OUT
    set_sums(0);
    i_sample = 8'd100;
    i_sample_valid = 1'b1;
    i_data_ready = 1'b1;
    check("bp_ready0", o_sample_ready, 1);
    tick();
    i_sample = 8'd101;
    check("busy_ready_c1", o_sample_ready, 0);
    check("busy_calc_c1", o_start_calc, 1);
    check("busy_taps_c1", longint'(o_taps[7:0]), 100);
    tick();
    check("busy_ready_c2", o_sample_ready, 0);
    check("busy_taps_c2", longint'(o_taps[7:0]), 100);
    tick();
    check("bp_data0", data_s(), 7);
    check("bp_idx0", longint'(o_filter_idx), 0);
    tick();
    check("bp_data1", data_s(), -8);
    check("bp_idx1", longint'(o_filter_idx), 1);
    i_data_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_valid", o_data_valid, 1);
      check("bp_hold_data", data_s(), -8);
      check("bp_hold_idx", longint'(o_filter_idx), 1);
      check("busy_hold_ready", o_sample_ready, 0);
      check("busy_hold_taps", longint'(o_taps[7:0]), 100);
    end
    i_data_ready = 1'b1;
    tick();
    check("bp_resume2", data_s(), 127);
    check("bp_resume_idx2", longint'(o_filter_idx), 2);
    tick();
    check("bp_resume3", data_s(), -128);
    check("bp_resume_idx3", longint'(o_filter_idx), 3);
    tick();
    check("busy_idle_ready", o_sample_ready, 1);
    check("busy_idle_taps", longint'(o_taps[7:0]), 100);
    tick();
    i_sample_valid = 1'b0;
    check("busy_shift_el0", longint'(o_taps[7:0]), 101);
    check("busy_shift_el1", longint'(o_taps[15:8]), 100);
    check("busy_shift_calc", o_start_calc, 1);
    $display("tx backpressure/busy-input sequence complete");

    // Async reset while streaming out idx 2
    tick();
    tick();
    tick();
    tick();
    check("mid_idx2", longint'(o_filter_idx), 2);
    check("mid_valid", o_data_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 1; k <= 6; k++) begin
      i_sample = B'(50 + k);
      i_sample_valid = 1'b1;
      tick();
      check("rewarm_calc", o_start_calc, 0);
      check("rewarm_full", o_window_full, 0);
    end
    i_sample = 8'd57;
    tick();
    i_sample_valid = 1'b0;
    check("rewarm_calc7", o_start_calc, 1);
    check("rewarm_full7", o_window_full, 1);
    repeat (8) tick();
    $display("tx mid-output reset and re-warm complete");

    // Random phase against a transaction-level reference model
    rst_n = 1'b0;
    i_sample_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NE; k++) win[k] = 0;
    accepted = 0;
    busy = 1'b0;
    exp_calc = 1'b0;
    valid_from = 0;
    txn = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_ready", o_sample_ready, !busy);
      check("rnd_calc", o_start_calc, exp_calc);
      check("rnd_full", o_window_full, accepted >= NE);
      if (exp_calc) begin
        for (int k = 0; k < NE; k++) exp_taps[B*k +: B] = win[k][B-1:0];
        check("rnd_taps", longint'(o_taps), longint'(exp_taps));
      end
      exp_valid = (q_data.size() > 0) && (cyc >= valid_from);
      check("rnd_valid", o_data_valid, exp_valid);
      if (exp_valid) begin
        check("rnd_data", data_s(), q_data[0]);
        check("rnd_idx", longint'(o_filter_idx), q_idx[0]);
      end

      vld = 1'($urandom_range(0, 1));
      smp = int'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 9) < 7);
      i_sample_valid = vld;
      i_sample = B'(smp);
      i_data_ready = rdy;

      cur_busy = busy;
      exp_calc = 1'b0;
      if (exp_valid && rdy) begin
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
        if (q_data.size() == 0) begin
          busy = 1'b0;
          txn++;
          $display("rnd tx %0d complete at cycle %0d", txn, cyc);
        end
      end
      if (vld && !cur_busy) begin
        for (int k = NE - 1; k > 0; k--) win[k] = win[k-1];
        win[0] = smp;
        accepted++;
        if (accepted >= NE) begin
          busy = 1'b1;
          exp_calc = 1'b1;
          valid_from = cyc + 3;
          for (int f = 0; f < NF; f++) begin
            int v;
            v = int'($urandom) >>> $urandom_range(0, 25);
            i_sums[32*f +: 32] = v;
            q_data.push_back(sat_ref(v));
            q_idx.push_back(f);
          end
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
